// File: rtl/my_ram_pkg.sv
// Shared types for the my_ram_512 memory and its two-port arbiter.
//   addr_t    : 9-bit word address
//   data_t    : 16-bit data word
//   state_t   : arbiter ownership states
//   RAM_DEPTH : number of words in my_ram_512
package my_ram_pkg;

  localparam int RAM_DEPTH = 512;
  localparam int HOLD_W    = 4;

  typedef logic [8:0]  addr_t;
  typedef logic [15:0] data_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

endpackage

// File: rtl/my_ram_512.sv
// 512 x 16 single-port RAM. Writes on the rising clock edge when load is
// high; reads are combinational from addr. Contents are never reset.
// Ports:
//   clk      : clock
//   load     : write enable
//   addr     : word address
//   data_in  : write data
//   data_out : combinational read data at addr
module my_ram_512
  import my_ram_pkg::*;
(
  input  logic  clk,
  input  logic  load,
  input  addr_t addr,
  input  data_t data_in,
  output data_t data_out
);

  data_t mem [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (load) mem[addr] <= data_in;
  end

  assign data_out = mem[addr];

endmodule

// File: rtl/my_ram_512_arbiter.sv
// Round-robin arbiter sharing one my_ram_512 between two requesters, with a
// bounded burst hold so an owner may stream up to BURST accesses while the
// other side waits.
// Ports (x = 0 or 1):
//   clk, rst_n : clock, asynchronous active-low reset
//   reqx       : access request, held until gntx
//   wex        : 1 = write, 0 = read
//   addrx      : word address
//   wdatax     : write data
//   gntx       : combinational grant for this cycle
//   rdatax     : registered read data
//   rvalidx    : one-cycle pulse, rdatax valid
//
// state | meaning
// IDLE  | no owner; a lone request is granted, a tie goes to !last
// OWN0  | requester 0 granted last cycle; may continue up to BURST grants
// OWN1  | requester 1 granted last cycle; may continue up to BURST grants
module my_ram_512_arbiter
  import my_ram_pkg::*;
#(
  parameter int BURST = 4,
  parameter int AW    = 9,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic [DW-1:0] rdata0,
  output logic          rvalid0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic [DW-1:0] rdata1,
  output logic          rvalid1
);

  localparam logic [HOLD_W-1:0] BURST_C = HOLD_W'(BURST);

  state_t            state, state_nx;
  logic              last;
  logic [HOLD_W-1:0] hold_cnt, hold_nx;

  addr_t ram_addr;
  data_t ram_in, ram_out;
  logic  ram_load;

  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    state_nx = IDLE;
    hold_nx  = '0;

    case (state)
      IDLE: begin
        // last==1 means requester 0 wins a tie
        if (req0 && (!req1 || last)) gnt0 = 1'b1;
        else if (req1)               gnt1 = 1'b1;
      end
      OWN0: begin
        if (req0 && (!req1 || hold_cnt < BURST_C)) gnt0 = 1'b1;
        else if (req1)                             gnt1 = 1'b1;
      end
      OWN1: begin
        if (req1 && (!req0 || hold_cnt < BURST_C)) gnt1 = 1'b1;
        else if (req0)                             gnt0 = 1'b1;
      end
      default: ;
    endcase

    // No grants (and therefore no RAM writes) while reset is asserted
    if (!rst_n) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end

    if (gnt0) begin
      state_nx = OWN0;
      if (state == OWN0) hold_nx = (hold_cnt < BURST_C) ? hold_cnt + 1'b1 : BURST_C;
      else               hold_nx = HOLD_W'(1);
    end else if (gnt1) begin
      state_nx = OWN1;
      if (state == OWN1) hold_nx = (hold_cnt < BURST_C) ? hold_cnt + 1'b1 : BURST_C;
      else               hold_nx = HOLD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= 1'b1;
      hold_cnt <= '0;
    end else begin
      state    <= state_nx;
      hold_cnt <= hold_nx;
      if (gnt0)      last <= 1'b0;
      else if (gnt1) last <= 1'b1;
    end
  end

  assign ram_addr = gnt1 ? addr1  : addr0;
  assign ram_in   = gnt1 ? wdata1 : wdata0;
  assign ram_load = (gnt0 & we0) | (gnt1 & we1);

  my_ram_512 u_ram (
    .clk      (clk),
    .load     (ram_load),
    .addr     (ram_addr),
    .data_in  (ram_in),
    .data_out (ram_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata0  <= '0;
      rdata1  <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
      if (gnt0 && !we0) rdata0 <= ram_out;
      if (gnt1 && !we1) rdata1 <= ram_out;
    end
  end

endmodule

// File: tb/tb_my_ram_512_arbiter.sv
// Self-checking bench for my_ram_512_arbiter. Read expectations are queued
// per port when the grant is seen; a monitor pops them on rvalid.
module tb_my_ram_512_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, we0, gnt0, rvalid0;
  logic        req1, we1, gnt1, rvalid1;
  logic [8:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1, rdata0, rdata1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] q0[$];
  logic [15:0] q1[$];

  my_ram_512_arbiter #(.BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rdata0(rdata0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rdata1(rdata1), .rvalid1(rvalid1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: mutual exclusion and read data scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      n_checks++;
      if (gnt0 && gnt1) begin
        n_fail++;
        $display("FAIL gnt_exclusive: got gnt0=%b gnt1=%b, expected at most one", gnt0, gnt1);
      end
      if (rvalid0) begin
        if (q0.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL rvalid0_unexpected: got rvalid0=1 rdata0=%h, expected no pulse", rdata0);
        end else check("rdata0", rdata0, q0.pop_front());
      end
      if (rvalid1) begin
        if (q1.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL rvalid1_unexpected: got rvalid1=1 rdata1=%h, expected no pulse", rdata1);
        end else check("rdata1", rdata1, q1.pop_front());
      end
    end
  end

  // Issue one access on port p; for reads d is the expected data.
  // Called just after a rising edge; returns just after a rising edge.
  task automatic access(input int p, input logic we, input logic [8:0] a, input logic [15:0] d);
    bit got = 0;
    if (p == 0) begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
    else        begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if ((p == 0) ? gnt0 : gnt1) begin got = 1; break; end
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL grant_timeout: got no gnt%0d in 20 cycles, expected gnt%0d=1", p, p);
    end else begin
      check("other_gnt_low", {15'd0, (p == 0) ? gnt1 : gnt0}, 16'd0);
      if (!we) begin
        if (p == 0) q0.push_back(d);
        else        q1.push_back(d);
      end
    end
    @(posedge clk); #1;
    if (p == 0) req0 = 0; else req1 = 0;
  endtask

  logic exp_g0 [9];

  initial begin
    exp_g0 = '{1, 1, 1, 1, 0, 0, 0, 0, 1};
    rst_n = 0;
    req0 = 1; we0 = 1; addr0 = 9'h000; wdata0 = 16'd2;
    req1 = 1; we1 = 1; addr1 = 9'h005; wdata1 = 16'd7;

    // Reset state with both requests high
    repeat (2) @(negedge clk);
    check("rst_gnt0", {15'd0, gnt0}, 16'd0);
    check("rst_gnt1", {15'd0, gnt1}, 16'd0);
    check("rst_rvalid0", {15'd0, rvalid0}, 16'd0);
    check("rst_rvalid1", {15'd0, rvalid1}, 16'd0);
    check("rst_rdata0", rdata0, 16'd0);
    check("rst_rdata1", rdata1, 16'd0);
    #1 rst_n = 1;
    #1;
    check("first_gnt0_tie", {15'd0, gnt0}, 16'd1);
    check("first_gnt1_tie", {15'd0, gnt1}, 16'd0);
    @(posedge clk); #1;
    req0 = 0; req1 = 0;

    // Single requester: read back the word written during the tie
    access(0, 0, 9'h000, 16'd2);

    // Preload, then one idle cycle so the FSM is in IDLE with last=1
    access(0, 1, 9'h010, 16'h1111);
    access(1, 1, 9'h020, 16'h2222);
    @(posedge clk); #1;

    // Contention: 0,0,0,0,1,1,1,1,0
    req0 = 1; we0 = 0; addr0 = 9'h010;
    req1 = 1; we1 = 0; addr1 = 9'h020;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check($sformatf("burst_gnt0[%0d]", i), {15'd0, gnt0}, {15'd0, exp_g0[i]});
      check($sformatf("burst_gnt1[%0d]", i), {15'd0, gnt1}, {15'd0, ~exp_g0[i]});
      if (exp_g0[i]) q0.push_back(16'h1111);
      else           q1.push_back(16'h2222);
      @(posedge clk); #1;
    end
    req0 = 0; req1 = 0;

    // Cross-port coherence in consecutive grants
    access(1, 1, 9'h1A7, 16'd9);
    access(0, 0, 9'h1A7, 16'd9);

    // Release mid-burst and idle
    req1 = 1; we1 = 0; addr1 = 9'h020;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rel_gnt1", {15'd0, gnt1}, 16'd1);
      q1.push_back(16'h2222);
      @(posedge clk); #1;
    end
    req1 = 0;
    @(negedge clk);
    check("idle_gnt0", {15'd0, gnt0}, 16'd0);
    check("idle_gnt1", {15'd0, gnt1}, 16'd0);
    @(posedge clk); #1;
    req1 = 1; addr1 = 9'h010;
    @(negedge clk);
    check("lone_gnt1", {15'd0, gnt1}, 16'd1);
    q1.push_back(16'h1111);
    @(posedge clk); #1;
    req1 = 0;

    // Async reset between a read grant and its rvalid
    access(0, 1, 9'h013, 16'd5);
    req0 = 1; we0 = 0; addr0 = 9'h013;
    @(negedge clk);
    check("mid_gnt0", {15'd0, gnt0}, 16'd1);
    @(posedge clk); #2;
    check("mid_rvalid0_high", {15'd0, rvalid0}, 16'd1);
    rst_n = 0;
    #1;
    check("mid_rvalid0_cleared", {15'd0, rvalid0}, 16'd0);
    check("mid_rdata0_cleared", rdata0, 16'd0);
    req0 = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    access(0, 0, 9'h013, 16'd5);

    repeat (3) @(posedge clk);
    #1;
    check("q0_drained", 16'(q0.size()), 16'd0);
    check("q1_drained", 16'(q1.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/my_ram_512_arbiter.md
Name: my_ram_512_arbiter

Overview:
- Shares one my_ram_512 (512 x 16, single port, write on rising clk when load=1, combinational read of addr) between two requesters.
- Round-robin arbitration with a bounded burst hold, so one requester can stream several accesses without starving the other.
- Instantiates the RAM internally. Sits between two client engines and the memory.

Parameters:
- BURST, 4, maximum consecutive grants to one owner while the other requester is asserting req (range 1..15).
- AW, 9, address width (fixed by my_ram_512; must not be overridden).
- DW, 16, data width (fixed by my_ram_512; must not be overridden).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0  in  1  requester 0 access request; held until gnt0.
- we0  in  1  requester 0: 1 = write, 0 = read; stable while req0 is high.
- addr0  in  9  requester 0 word address.
- wdata0  in  16  requester 0 write data.
- gnt0  out  1  access accepted this cycle (combinational from req and state).
- rdata0  out  16  registered read data for requester 0.
- rvalid0  out  1  one-cycle pulse; rdata0 is valid.
- req1, we1, addr1, wdata1, gnt1, rdata1, rvalid1: identical for requester 1.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, last=1 (requester 0 wins the first tie), hold_cnt=0, gnt*=0, rvalid*=0, rdata*=0, RAM load forced 0. RAM contents are not cleared.
- FSM states IDLE, OWN0, OWN1; hold_cnt is 4 bits.
- IDLE:
  - Only one req high: grant it; go to OWNx; hold_cnt=1.
  - Both high: grant !last.
  - Neither high: stay IDLE.
- OWNx, reqx high and (req of other low, or hold_cnt < BURST): grant x again; hold_cnt++ (saturates at BURST).
- OWNx, other req high and (hold_cnt == BURST, or reqx low): grant other; go to OWN(other); hold_cnt=1.
- OWNx, no req: go to IDLE; hold_cnt=0.
- last updates to the granted index on every grant.
- At most one gnt per cycle; gnt0 & gnt1 == 0 always.
- Granted cycle datapath: RAM addr/in come from the winner, and load = winner's we. A write commits at that rising edge.
- Read: on the grant edge, rdata of the winner is loaded from RAM out, and rvalid of the winner pulses high for exactly the next cycle. Latency is 1 cycle from grant to rvalid. A write grant produces no rvalid.
- Ungranted cycle: RAM load=0; rdata holds its previous value.
- Requester rule: keep req/we/addr/wdata stable until gnt is seen. Dropping req before gnt is legal; the request is simply abandoned.
- Read-after-write to the same address in consecutive grants returns the new data (the write commits before the next read samples).
- Simultaneous write by owner and new request from the other: the owner finishes its burst as above; no request is lost.
- rst_n asserted mid-burst: any in-flight rvalid is cleared immediately. A write on the edge coinciding with reset assertion is not guaranteed.
- BURST=1 degenerates to strict alternation under contention.

Decomposition:
- Shared package my_ram_pkg: typedef addr_t [8:0], data_t [15:0], enum state_t {IDLE, OWN0, OWN1}, constant RAM_DEPTH=512.
- One sub-module: my_ram_512, instantiated unchanged. The arbiter FSM, mux and read registers stay in this module.

Test Plan:
- Reset: rst_n=0 with req0=req1=1 -> gnt0=gnt1=0, rvalid*=0, rdata*=0. Release rst_n -> gnt0=1 on the first cycle (tie goes to 0).
- Single requester: req0 writes 16'd2 @9'h000 then reads @9'h000 -> gnt0 each cycle, rvalid0 pulses one cycle after the read grant, rdata0=2. gnt1 stays 0.
- Contention with BURST=4: req0 and req1 held high with reads at distinct addresses -> grants in the sequence 0,0,0,0,1,1,1,1,0. Never both gnt high.
- Cross-port coherence: port1 writes 16'd9 @9'h1A7; next cycle port0 reads 9'h1A7 -> rdata0=9, rvalid0 pulse.
- Release and idle: req1 drops mid-burst while req0 is low -> FSM returns to IDLE and gnt*=0. A later lone req1 -> gnt1 on the same cycle.
- Async reset mid-read: assert rst_n between a read grant and its rvalid -> rvalid0 forced 0 immediately. After release, a read of a previously written address (16'd5 @9'h013) still returns 5, since RAM is not cleared.
